// File: rtl/vec_mem_arb_ram_if.sv
// Request bus for vec_mem_arb_ram: NUM_PORTS picorv32-style valid/ready ports, flattened per port.
// req_err exists only when VEC_MEM_ERR_EN is defined.
`timescale 1ns/1ps
interface vec_mem_arb_ram_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]    req_valid;
    logic [NUM_PORTS-1:0]    req_ready;
    logic [NUM_PORTS*32-1:0] req_addr;
    logic [NUM_PORTS*32-1:0] req_wdata;
    logic [NUM_PORTS*4-1:0]  req_wstrb;
    logic [NUM_PORTS*32-1:0] req_rdata;
`ifdef VEC_MEM_ERR_EN
    logic [NUM_PORTS-1:0]    req_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb,
        input  req_ready, req_rdata, req_err
    );
    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb,
        output req_ready, req_rdata, req_err
    );
`else
    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb,
        input  req_ready, req_rdata
    );
    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb,
        output req_ready, req_rdata
    );
`endif
endinterface

// File: rtl/vec_mem_arb_ram.sv
// Shared word RAM behind a round-robin arbiter; one transaction at a time, ready after LATENCY cycles.
// Optional out-of-range error pulse on req_err when VEC_MEM_ERR_EN is defined.
`timescale 1ns/1ps
module vec_mem_arb_ram #(
    parameter int NUM_PORTS = 2,
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 1
) (
    input  logic             clk,
    input  logic             resetn,
    vec_mem_arb_ram_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = 4;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                  r_state, w_state_nxt;
    logic [PW-1:0]           r_rr, r_gnt;
    logic [CW-1:0]           r_cnt;
    logic [NUM_PORTS-1:0]    r_ready_last;
    logic [NUM_PORTS*32-1:0] r_rdata_hold;
    logic [AW-1:0]           r_word;
    logic                    r_oor;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;
    logic [31:0]             r_mem [MEM_WORDS];

    logic [NUM_PORTS-1:0]    w_elig;
    logic                    w_found;
    logic [PW-1:0]           w_pick;
    logic [31:0]             w_addr, w_wdata;
    logic [3:0]              w_wstrb;
    int                      w_best, w_dist;
    logic                    w_done;
    logic [31:0]             w_rdq;
    logic [NUM_PORTS-1:0]    w_ready;
    logic [NUM_PORTS*32-1:0] w_rdata;

    // Rotating priority: the eligible port at the smallest distance past r_rr wins.
    always_comb begin
        w_elig  = bus.req_valid & ~r_ready_last;
        w_found = 1'b0;
        w_pick  = r_rr;
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        w_best  = NUM_PORTS;
        w_dist  = 0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (w_elig[j]) begin
                w_dist = (j + NUM_PORTS - int'(r_rr)) % NUM_PORTS;
                if (w_dist < w_best) begin
                    w_best  = w_dist;
                    w_found = 1'b1;
                    w_pick  = PW'(j);
                    w_addr  = bus.req_addr[j*32 +: 32];
                    w_wdata = bus.req_wdata[j*32 +: 32];
                    w_wstrb = bus.req_wstrb[j*4 +: 4];
                end
            end
        end
    end

    assign w_done = (r_state == S_BUSY) && (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_done)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_rr         <= '0;
            r_gnt        <= '0;
            r_cnt        <= '0;
            r_ready_last <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ready_last <= w_ready;
            if ((r_state == S_IDLE) && w_found) begin
                r_gnt <= w_pick;
                r_cnt <= CW'(LATENCY - 1);
            end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_done) begin
                r_rr         <= (r_gnt == PW'(NUM_PORTS - 1)) ? '0 : r_gnt + 1'b1;
                r_rdata_hold <= w_rdata;
            end
        end
    end

    // Async reset drops r_state to IDLE at once, so an abandoned write never reaches the RAM.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && w_found) begin
            r_word  <= w_addr[AW+1:2];
            r_oor   <= (w_addr >> (AW + 2)) != 32'd0;
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
        end
        if (w_done && !r_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) r_mem[r_word][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
        end
    end

    assign w_rdq = r_oor ? 32'd0 : r_mem[r_word];

    always_comb begin
        w_ready = '0;
        w_rdata = r_rdata_hold;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (w_done && (r_gnt == PW'(j))) begin
                w_ready[j]           = 1'b1;
                w_rdata[j*32 +: 32]  = w_rdq;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.req_rdata = w_rdata;
`ifdef VEC_MEM_ERR_EN
    assign bus.req_err   = w_ready & {NUM_PORTS{r_oor}};
`endif
endmodule
